control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-002 SHALL have port clear, input, 1 bit: synchronous active-high reset.
REQ-003 SHALL have port IR, input, 32 bits: instruction register; opcode = IR[31:27].
REQ-004 SHALL have port con_ff, input, 1 bit: branch-condition flag from the datapath.
REQ-005 SHALL have datapath control outputs, each 1 bit: PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout, PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Gra, Grb, Grc, Rin, Rout, read, write, OutPort, CONin, IncPC, AND, OR, ADD, SUB, MUL, DIV, SHR, SHL, ROR, ROL, NEG, NOT.
REQ-006 SHALL have port run, output, 1 bit: high unless in RESET or HALT.

Function
REQ-007 SHALL be a Moore FSM; outputs decode from the state register only; an unlisted output is 0 in that state.
REQ-008 SHALL use states RESET, T0..T7, HALT; RESET -> T0 unconditionally; each instruction's last step -> T0.
REQ-009 Fetch: T0 PCout MARin IncPC Zin; T1 Zlowout PCin read MDRin; T2 MDRout IRin; T3 onward decodes the IR value latched at T2.
REQ-010 Opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, addi 01011, andi 01100, ori 01101, mul 01110, div 01111, neg 10000, not 10001, br 10010, jr 10011, in 10101, out 10110, mfhi 10111, mflo 11000, nop 11001, halt 11010.
REQ-011 R-type (add..rol): T3 Grb Rout Yin; T4 Grc Rout <op> Zin; T5 Zlowout Gra Rin.
REQ-012 addi/andi/ori: T3 Grb Rout Yin; T4 Cout ADD/AND/OR Zin; T5 Zlowout Gra Rin.
REQ-013 ldi: T3 Grb BAout Yin; T4 Cout ADD Zin; T5 Zlowout Gra Rin.
REQ-014 ld: T3-T4 as ldi; T5 Zlowout MARin; T6 read MDRin; T7 MDRout Gra Rin.
REQ-015 st: T3-T5 as ld; T6 Gra Rout MDRin; T7 write (read=0).
REQ-016 neg/not: T3 Grb Rout NEG/NOT Zin; T4 Zlowout Gra Rin.
REQ-017 mul/div: T3 Gra Rout Yin; T4 Grb Rout MUL/DIV Zin; T5 Zlowout LOin; T6 Zhighout HIin.
REQ-018 br: T3 Gra Rout CONin; T4 PCout Yin; T5 Cout ADD Zin; T6 Zlowout, plus PCin only if con_ff=1 during T6.
REQ-019 jr: T3 Gra Rout PCin. in: T3 Inportout Gra Rin. out: T3 Gra Rout OutPort. mfhi: T3 HIout Gra Rin. mflo: T3 LOout Gra Rin.
REQ-020 nop: T2 -> T0 (3-cycle instruction).
REQ-021 halt and any undefined opcode (10100, 11011-11111): T2 -> HALT; HALT holds all outputs 0, run=0, exits only via clear.
REQ-022 read and write SHALL never be 1 in the same cycle; at most one bus-driver output (*out, Rout, BAout) SHALL be 1 per cycle.

Reset
REQ-023 clear=1 at a rising edge SHALL force state to RESET regardless of current state, including mid-instruction and HALT.
REQ-024 In RESET all outputs SHALL be 0 and run=0; first T0 occurs in the cycle after the first edge with clear=0.

Configuration
REQ-025 Macro CU_MULDIV_EN defined: mul/div execute per REQ-017.
REQ-026 Macro CU_MULDIV_EN undefined: opcodes 01110/01111 SHALL behave as nop (T2 -> T0), and MUL, DIV, HIin, LOin SHALL be constant 0.

Verification
REQ-027 clear 2 cycles then release -> RESET, T0 (PCout MARin IncPC Zin), T1, T2 at consecutive edges; run 0 then 1.
REQ-028 IR=0x18918000 (add R1,R2,R3) -> T3 Grb Rout Yin; T4 Grc Rout ADD Zin; T5 Zlowout Gra Rin; next cycle T0; 6 cycles total.
REQ-029 IR=0x00800005 (ld R1,5(R0)) -> T3 BAout, T6 read MDRin, T7 MDRout Gra Rin; write=0 throughout; 8 cycles.
REQ-030 IR=0x90800003 (br) with con_ff=0, then repeated with con_ff=1 -> PCin absent, then present, at T6.
REQ-031 IR=0xD0000000 -> HALT after T2, run=0 for 20 cycles; clear mid-HALT -> RESET, then T0.
REQ-032 clear asserted during T4 of mul -> next state RESET, LOin/HIin never asserted; with CU_MULDIV_EN undefined, mul -> T0 after T2.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore control sequencer for a 32-bit datapath.
// Fetch T0..T2, execute T3..T7, plus RESET and HALT states.
// Optional feature macro: CU_MULDIV_EN enables the mul/div sequences; when
// undefined, mul/div decode as nop and MUL, DIV, HIin, LOin stay 0.
module control_unit (
    input  logic        clk,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        con_ff,
    output logic        PCout,
    output logic        Zhighout,
    output logic        Zlowout,
    output logic        MDRout,
    output logic        HIout,
    output logic        LOout,
    output logic        Inportout,
    output logic        Cout,
    output logic        BAout,
    output logic        PCin,
    output logic        IRin,
    output logic        MARin,
    output logic        Yin,
    output logic        HIin,
    output logic        LOin,
    output logic        Zin,
    output logic        MDRin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic        read,
    output logic        write,
    output logic        OutPort,
    output logic        CONin,
    output logic        IncPC,
    output logic        AND,
    output logic        OR,
    output logic        ADD,
    output logic        SUB,
    output logic        MUL,
    output logic        DIV,
    output logic        SHR,
    output logic        SHL,
    output logic        ROR,
    output logic        ROL,
    output logic        NEG,
    output logic        NOT,
    output logic        run
);

    localparam int unsigned OP_W   = 5;
    localparam int unsigned STEP_W = 3;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01010;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01011;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01101;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10001;
    localparam logic [OP_W-1:0] OP_BR   = 5'b10010;
    localparam logic [OP_W-1:0] OP_JR   = 5'b10011;
    localparam logic [OP_W-1:0] OP_IN   = 5'b10101;
    localparam logic [OP_W-1:0] OP_OUT  = 5'b10110;
    localparam logic [OP_W-1:0] OP_MFHI = 5'b10111;
    localparam logic [OP_W-1:0] OP_MFLO = 5'b11000;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11001;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11010;

    // Low three bits of the T-states equal the step number.
    typedef enum logic [3:0] {
        T0    = 4'd0,
        T1    = 4'd1,
        T2    = 4'd2,
        T3    = 4'd3,
        T4    = 4'd4,
        T5    = 4'd5,
        T6    = 4'd6,
        T7    = 4'd7,
        RESET = 4'd8,
        HALT  = 4'd9
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [OP_W-1:0]   ir_op;
    logic [3:0]        state_bits;
    logic [STEP_W-1:0] live_last;
    logic [STEP_W-1:0] held_last;
    logic              unused_ir;

    assign state_bits = state;
    assign unused_ir  = ^IR[26:0];

    // Final execute step of an opcode: 0 = halt/undefined, 2 = ends after fetch.
    function automatic logic [STEP_W-1:0] last_step(input logic [OP_W-1:0] op);
        case (op)
            OP_LD, OP_ST:                               last_step = 3'd7;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR,
            OP_SHR, OP_SHL, OP_ROR, OP_ROL,
            OP_ADDI, OP_ANDI, OP_ORI:                   last_step = 3'd5;
`ifdef CU_MULDIV_EN
            OP_MUL, OP_DIV:                             last_step = 3'd6;
`else
            OP_MUL, OP_DIV:                             last_step = 3'd2;
`endif
            OP_NEG, OP_NOT:                             last_step = 3'd4;
            OP_BR:                                      last_step = 3'd6;
            OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO:     last_step = 3'd3;
            OP_NOP:                                     last_step = 3'd2;
            OP_HALT:                                    last_step = 3'd0;
            default:                                    last_step = 3'd0;
        endcase
    endfunction

    // State register with synchronous clear.
    always_ff @(posedge clk) begin
        if (clear) begin
            state <= RESET;
        end else begin
            state <= next_state;
        end
    end

    // Opcode captured as the instruction is loaded at T2.
    always_ff @(posedge clk) begin
        if (clear) begin
            ir_op <= '0;
        end else if (state == T2) begin
            ir_op <= IR[31:27];
        end
    end

    // Next-state logic: fetch sequence, then step until the opcode's last step.
    always_comb begin
        next_state = state;
        live_last  = last_step(IR[31:27]);
        held_last  = last_step(ir_op);
        case (state)
            RESET: next_state = T0;
            T0:    next_state = T1;
            T1:    next_state = T2;
            T2: begin
                if (live_last == 3'd0) begin
                    next_state = HALT;
                end else if (live_last == 3'd2) begin
                    next_state = T0;
                end else begin
                    next_state = T3;
                end
            end
            T3, T4, T5, T6, T7: begin
                if (state_bits[2:0] >= held_last) begin
                    next_state = T0;
                end else begin
                    next_state = state_t'(state_bits + 4'd1);
                end
            end
            HALT:    next_state = HALT;
            default: next_state = RESET;
        endcase
    end

    // Output decode from the state register and latched opcode.
    always_comb begin
        {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout,
         PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Gra, Grb, Grc, Rin, Rout,
         read, write, OutPort, CONin, IncPC, AND, OR, ADD, SUB, MUL, DIV, SHR,
         SHL, ROR, ROL, NEG, NOT} = '0;
        run = (state != RESET) && (state != HALT);
        case (state)
            T0: begin
                PCout = 1'b1; MARin = 1'b1; IncPC = 1'b1; Zin = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
            end
            T2: begin
                MDRout = 1'b1; IRin = 1'b1;
            end
            T3: begin
                case (ir_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        Grb = 1'b1; Rout = 1'b1; Yin = 1'b1;
                    end
                    OP_LDI, OP_LD, OP_ST: begin
                        Grb = 1'b1; BAout = 1'b1; Yin = 1'b1;
                    end
                    OP_NEG: begin Grb = 1'b1; Rout = 1'b1; NEG = 1'b1; Zin = 1'b1; end
                    OP_NOT: begin Grb = 1'b1; Rout = 1'b1; NOT = 1'b1; Zin = 1'b1; end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin Gra = 1'b1; Rout = 1'b1; Yin = 1'b1; end
`endif
                    OP_BR:   begin Gra = 1'b1; Rout = 1'b1; CONin = 1'b1; end
                    OP_JR:   begin Gra = 1'b1; Rout = 1'b1; PCin = 1'b1; end
                    OP_IN:   begin Inportout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_OUT:  begin Gra = 1'b1; Rout = 1'b1; OutPort = 1'b1; end
                    OP_MFHI: begin HIout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_MFLO: begin LOout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    default: ;
                endcase
            end
            T4: begin
                case (ir_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL: begin
                        Grc = 1'b1; Rout = 1'b1; Zin = 1'b1;
                    end
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI, OP_LD, OP_ST: begin
                        Cout = 1'b1; Zin = 1'b1;
                    end
                    OP_NEG, OP_NOT: begin Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin Grb = 1'b1; Rout = 1'b1; Zin = 1'b1; end
`endif
                    OP_BR:   begin PCout = 1'b1; Yin = 1'b1; end
                    default: ;
                endcase
                // ALU operation select for the T4 compute step
                case (ir_op)
                    OP_ADD, OP_ADDI, OP_LDI, OP_LD, OP_ST: ADD = 1'b1;
                    OP_SUB:          SUB = 1'b1;
                    OP_AND, OP_ANDI: AND = 1'b1;
                    OP_OR, OP_ORI:   OR  = 1'b1;
                    OP_SHR:          SHR = 1'b1;
                    OP_SHL:          SHL = 1'b1;
                    OP_ROR:          ROR = 1'b1;
                    OP_ROL:          ROL = 1'b1;
`ifdef CU_MULDIV_EN
                    OP_MUL:          MUL = 1'b1;
                    OP_DIV:          DIV = 1'b1;
`endif
                    default: ;
                endcase
            end
            T5: begin
                case (ir_op)
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI, OP_LDI: begin
                        Zlowout = 1'b1; Gra = 1'b1; Rin = 1'b1;
                    end
                    OP_LD, OP_ST: begin Zlowout = 1'b1; MARin = 1'b1; end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin Zlowout = 1'b1; LOin = 1'b1; end
`endif
                    OP_BR:   begin Cout = 1'b1; ADD = 1'b1; Zin = 1'b1; end
                    default: ;
                endcase
            end
            T6: begin
                case (ir_op)
                    OP_LD: begin read = 1'b1; MDRin = 1'b1; end
                    OP_ST: begin Gra = 1'b1; Rout = 1'b1; MDRin = 1'b1; end
`ifdef CU_MULDIV_EN
                    OP_MUL, OP_DIV: begin Zhighout = 1'b1; HIin = 1'b1; end
`endif
                    OP_BR: begin Zlowout = 1'b1; PCin = con_ff; end
                    default: ;
                endcase
            end
            T7: begin
                case (ir_op)
                    OP_LD:   begin MDRout = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    OP_ST:   write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_unit.sv
// Testbench for control_unit: directed instruction scenarios plus randomized
// instruction streams checked against a per-opcode micro-step model.
module tb_control_unit;

    logic        clk = 1'b0;
    logic        clear;
    logic [31:0] IR;
    logic        con_ff;
    logic PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Inportout, Cout, BAout;
    logic PCin, IRin, MARin, Yin, HIin, LOin, Zin, MDRin, Gra, Grb, Grc, Rin, Rout;
    logic read, write, OutPort, CONin, IncPC, AND, OR, ADD, SUB, MUL, DIV;
    logic SHR, SHL, ROR, ROL, NEG, NOT, run;

    control_unit dut (
        .clk(clk), .clear(clear), .IR(IR), .con_ff(con_ff),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Inportout(Inportout), .Cout(Cout),
        .BAout(BAout), .PCin(PCin), .IRin(IRin), .MARin(MARin), .Yin(Yin),
        .HIin(HIin), .LOin(LOin), .Zin(Zin), .MDRin(MDRin), .Gra(Gra), .Grb(Grb),
        .Grc(Grc), .Rin(Rin), .Rout(Rout), .read(read), .write(write),
        .OutPort(OutPort), .CONin(CONin), .IncPC(IncPC), .AND(AND), .OR(OR),
        .ADD(ADD), .SUB(SUB), .MUL(MUL), .DIV(DIV), .SHR(SHR), .SHL(SHL),
        .ROR(ROR), .ROL(ROL), .NEG(NEG), .NOT(NOT), .run(run)
    );

    always #5 clk = ~clk;

    logic [39:0] obs;
    assign obs = {run, NOT, NEG, ROL, ROR, SHL, SHR, DIV, MUL, SUB, ADD, OR, AND,
                  IncPC, CONin, OutPort, write, read, Rout, Rin, Grc, Grb, Gra,
                  MDRin, Zin, LOin, HIin, Yin, MARin, IRin, PCin, BAout, Cout,
                  Inportout, LOout, HIout, MDRout, Zlowout, Zhighout, PCout};

    localparam logic [39:0] K_PCOUT = 40'd1 << 0;
    localparam logic [39:0] K_ZHI   = 40'd1 << 1;
    localparam logic [39:0] K_ZLO   = 40'd1 << 2;
    localparam logic [39:0] K_MDRO  = 40'd1 << 3;
    localparam logic [39:0] K_HIO   = 40'd1 << 4;
    localparam logic [39:0] K_LOO   = 40'd1 << 5;
    localparam logic [39:0] K_INPO  = 40'd1 << 6;
    localparam logic [39:0] K_COUT  = 40'd1 << 7;
    localparam logic [39:0] K_BAO   = 40'd1 << 8;
    localparam logic [39:0] K_PCIN  = 40'd1 << 9;
    localparam logic [39:0] K_IRIN  = 40'd1 << 10;
    localparam logic [39:0] K_MARIN = 40'd1 << 11;
    localparam logic [39:0] K_YIN   = 40'd1 << 12;
    localparam logic [39:0] K_HIIN  = 40'd1 << 13;
    localparam logic [39:0] K_LOIN  = 40'd1 << 14;
    localparam logic [39:0] K_ZIN   = 40'd1 << 15;
    localparam logic [39:0] K_MDRIN = 40'd1 << 16;
    localparam logic [39:0] K_GRA   = 40'd1 << 17;
    localparam logic [39:0] K_GRB   = 40'd1 << 18;
    localparam logic [39:0] K_GRC   = 40'd1 << 19;
    localparam logic [39:0] K_RIN   = 40'd1 << 20;
    localparam logic [39:0] K_ROUT  = 40'd1 << 21;
    localparam logic [39:0] K_READ  = 40'd1 << 22;
    localparam logic [39:0] K_WRITE = 40'd1 << 23;
    localparam logic [39:0] K_OUTP  = 40'd1 << 24;
    localparam logic [39:0] K_CONIN = 40'd1 << 25;
    localparam logic [39:0] K_INCPC = 40'd1 << 26;
    localparam logic [39:0] K_AND   = 40'd1 << 27;
    localparam logic [39:0] K_OR    = 40'd1 << 28;
    localparam logic [39:0] K_ADD   = 40'd1 << 29;
    localparam logic [39:0] K_SUB   = 40'd1 << 30;
    localparam logic [39:0] K_MUL   = 40'd1 << 31;
    localparam logic [39:0] K_DIV   = 40'd1 << 32;
    localparam logic [39:0] K_SHR   = 40'd1 << 33;
    localparam logic [39:0] K_SHL   = 40'd1 << 34;
    localparam logic [39:0] K_ROR   = 40'd1 << 35;
    localparam logic [39:0] K_ROL   = 40'd1 << 36;
    localparam logic [39:0] K_NEG   = 40'd1 << 37;
    localparam logic [39:0] K_NOT   = 40'd1 << 38;
    localparam logic [39:0] K_RUN   = 40'd1 << 39;
    localparam logic [39:0] K_BUS   = K_PCOUT | K_ZHI | K_ZLO | K_MDRO | K_HIO |
                                      K_LOO | K_INPO | K_COUT | K_BAO | K_ROUT;

    int checks = 0;
    int errors = 0;
    logic [39:0] exp_q[$];

    task automatic check(input string tag, input logic [39:0] o, input logic [39:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Bus-exclusivity and read/write exclusivity hold in every cycle.
    task automatic check_excl(input string tag);
        logic ok;
        ok = !(read && write) && ($countones(obs & K_BUS) <= 1);
        checks++;
        assert (ok === 1'b1) else begin
            errors++;
            $error("FAIL %s_excl observed=%h expected=exclusive", tag, obs);
        end
    endtask

    function automatic void push(input logic [39:0] m);
        exp_q.push_back(m | K_RUN);
    endfunction

    // Reference micro-program: list of control words, one per cycle from T0.
    task automatic model(input logic [4:0] op, input logic con, output bit halts);
        logic [39:0] alu;
        halts = 1'b0;
        exp_q.delete();
        push(K_PCOUT | K_MARIN | K_INCPC | K_ZIN);
        push(K_ZLO | K_PCIN | K_READ | K_MDRIN);
        push(K_MDRO | K_IRIN);
        case (op)
            5'd3:  alu = K_ADD;  5'd4:  alu = K_SUB;  5'd5:  alu = K_AND;
            5'd6:  alu = K_OR;   5'd7:  alu = K_SHR;  5'd8:  alu = K_SHL;
            5'd9:  alu = K_ROR;  5'd10: alu = K_ROL;  5'd11: alu = K_ADD;
            5'd12: alu = K_AND;  5'd13: alu = K_OR;   default: alu = K_ADD;
        endcase
        case (op)
            5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10: begin
                push(K_GRB | K_ROUT | K_YIN);
                push(K_GRC | K_ROUT | alu | K_ZIN);
                push(K_ZLO | K_GRA | K_RIN);
            end
            5'd11, 5'd12, 5'd13: begin
                push(K_GRB | K_ROUT | K_YIN);
                push(K_COUT | alu | K_ZIN);
                push(K_ZLO | K_GRA | K_RIN);
            end
            5'd1: begin
                push(K_GRB | K_BAO | K_YIN);
                push(K_COUT | K_ADD | K_ZIN);
                push(K_ZLO | K_GRA | K_RIN);
            end
            5'd0, 5'd2: begin
                push(K_GRB | K_BAO | K_YIN);
                push(K_COUT | K_ADD | K_ZIN);
                push(K_ZLO | K_MARIN);
                if (op == 5'd0) begin
                    push(K_READ | K_MDRIN);
                    push(K_MDRO | K_GRA | K_RIN);
                end else begin
                    push(K_GRA | K_ROUT | K_MDRIN);
                    push(K_WRITE);
                end
            end
            5'd14, 5'd15: begin
`ifdef CU_MULDIV_EN
                push(K_GRA | K_ROUT | K_YIN);
                push(K_GRB | K_ROUT | ((op == 5'd14) ? K_MUL : K_DIV) | K_ZIN);
                push(K_ZLO | K_LOIN);
                push(K_ZHI | K_HIIN);
`endif
            end
            5'd16, 5'd17: begin
                push(K_GRB | K_ROUT | ((op == 5'd16) ? K_NEG : K_NOT) | K_ZIN);
                push(K_ZLO | K_GRA | K_RIN);
            end
            5'd18: begin
                push(K_GRA | K_ROUT | K_CONIN);
                push(K_PCOUT | K_YIN);
                push(K_COUT | K_ADD | K_ZIN);
                push(K_ZLO | (con ? K_PCIN : 40'd0));
            end
            5'd19: push(K_GRA | K_ROUT | K_PCIN);
            5'd21: push(K_INPO | K_GRA | K_RIN);
            5'd22: push(K_GRA | K_ROUT | K_OUTP);
            5'd23: push(K_HIO | K_GRA | K_RIN);
            5'd24: push(K_LOO | K_GRA | K_RIN);
            5'd25: ;
            default: halts = 1'b1;
        endcase
    endtask

    // Run one instruction starting in a T0 cycle; ends in the next T0 cycle.
    task automatic do_instr(input logic [31:0] ir, input logic con,
                            input int abort_at, input int halt_cycles);
        bit halts;
        int n;
        model(ir[31:27], con, halts);
        n = exp_q.size();
        IR = ir;
        con_ff = con;
        for (int i = 0; i < n; i++) begin
            if (i == 3) IR = $urandom;
            check($sformatf("ir%08h_t%0d", ir, i), obs, exp_q[i]);
            check_excl($sformatf("ir%08h_t%0d", ir, i));
            if (i == abort_at) begin
                clear = 1'b1;
                @(posedge clk); #1;
                check($sformatf("ir%08h_abort_reset", ir), obs, 40'd0);
                clear = 1'b0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        if (halts) begin
            for (int c = 0; c < halt_cycles; c++) begin
                check($sformatf("ir%08h_halt%0d", ir, c), obs, 40'd0);
                @(posedge clk); #1;
            end
            clear = 1'b1;
            @(posedge clk); #1;
            check($sformatf("ir%08h_halt_reset", ir), obs, 40'd0);
            clear = 1'b0;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rir;
        clear  = 1'b1;
        IR     = 32'd0;
        con_ff = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", obs, 40'd0);
        clear = 1'b0;
        @(posedge clk); #1;

        do_instr(32'h18918000, 1'b0, -1, 0);   // add R1,R2,R3
        do_instr(32'h00800005, 1'b0, -1, 0);   // ld R1,5(R0)
        do_instr(32'h90800003, 1'b0, -1, 0);   // br, not taken
        do_instr(32'h90800003, 1'b1, -1, 0);   // br, taken
        do_instr(32'h10000000, 1'b0, -1, 0);   // st
        do_instr(32'hC8000000, 1'b0, -1, 0);   // nop
        do_instr(32'h70000000, 1'b0, 4, 0);    // mul, cleared at T4
        do_instr(32'h78000000, 1'b0, -1, 0);   // div
        do_instr(32'h00800005, 1'b0, 5, 0);    // ld, cleared at T5
        do_instr(32'hD0000000, 1'b0, -1, 20);  // halt
        do_instr(32'hA0000000, 1'b0, -1, 3);   // undefined 10100
        do_instr(32'hF8000000, 1'b0, -1, 3);   // undefined 11111

        for (int k = 0; k < 300; k++) begin
            rir = $urandom;
            do_instr(rir, 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 15) == 0) ? int'($urandom_range(0, 7)) : -1,
                     int'($urandom_range(1, 4)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
